// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline boundary register with a valid/ready handshake,
// synchronous flush and an optional two-entry skid buffer.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> main + skid register; in_ready_o is a flop.
//                       undefined -> main register only; in_ready_o depends
//                                    combinationally on out_ready_i.
//
// Parameters:
//   DATA_W     payload width in bits (>= 1)
//   RESET_VAL  payload shown after reset or flush; must encode a NOP
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   flush_i      synchronous flush, kills every held entry at the next edge
//   in_valid_i   upstream payload valid
//   in_ready_o   stage accepts the payload this cycle
//   in_data_i    upstream payload
//   out_valid_o  downstream payload valid
//   out_ready_i  downstream accepts this cycle (low = stall)
//   out_data_o   downstream payload
//   count_o      number of entries held (0..2, 0..1 without the skid buffer)
module pipe_stage_reg #(
    parameter int unsigned        DATA_W    = 32,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    // Encoding equals the number of held entries, so count_o is the state itself.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] md_q, md_d;
    logic              mv;
    logic              accept;
    logic              fire;

    assign mv          = (state_q != StEmpty);
    assign out_valid_o = mv;
    assign out_data_o  = md_q;
    assign accept      = in_valid_i && in_ready_o;
    assign fire        = mv && out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] sd_q, sd_d;
    logic              ready_q;

    // Registered ready: high whenever the skid slot is free.
    assign in_ready_o = ready_q;
    assign count_o    = state_q;
`else
    // Without a skid slot the main register may refill in the cycle it drains.
    assign in_ready_o = !mv || out_ready_i;
    assign count_o    = {1'b0, state_q[0]};
`endif

    always_comb begin
        state_d = state_q;
        md_d    = md_q;
`ifdef PIPE_STAGE_SKID_EN
        sd_d    = sd_q;
`endif
        if (flush_i) begin
            // Flush wins over any accept or fire in the same cycle.
            state_d = StEmpty;
            md_d    = RESET_VAL;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        md_d    = in_data_i;
                    end
                end
                StOne: begin
                    if (accept && fire) begin
                        md_d = in_data_i;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (accept) begin
                        // Downstream stalled: park the new word in the skid slot.
                        state_d = StTwo;
                        sd_d    = in_data_i;
`endif
                    end else if (fire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (fire) begin
                        state_d = StOne;
                        md_d    = sd_q;
                    end
`else
                    state_d = StEmpty;
`endif
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
            md_q    <= RESET_VAL;
        end else begin
            state_q <= state_d;
            md_q    <= md_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b1;
            sd_q    <= RESET_VAL;
        end else begin
            ready_q <= (state_d != StTwo);
            sd_q    <= sd_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int unsigned W     = 8;
    localparam logic [W-1:0] RVAL = 8'hC3;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int checks;
    int errors;

    // Reference model: a FIFO of held words plus the last word shown.
    logic [W-1:0] mq[$];
    logic [W-1:0] last;

    pipe_stage_reg #(
        .DATA_W   (W),
        .RESET_VAL(RVAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .count_o    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         v;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         e_valid;
        logic [W-1:0] e_data;
        logic         e_ready;
        logic [1:0]   e_count;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    task automatic check_model(input string tag);
        logic [W-1:0] ed;
        ed = (mq.size() != 0) ? mq[0] : last;
        chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, mq.size() != 0});
        chk({tag, ".data"}, out_data, ed);
        chk({tag, ".ready"}, {7'd0, in_ready}, {7'd0, model_ready()});
        chk({tag, ".count"}, {6'd0, count}, 8'(mq.size()));
    endtask

    task automatic model_reset();
        mq.delete();
        last = RVAL;
    endtask

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic acc;
        logic fire;
        if (!rst) begin
            model_reset();
        end else if (flush) begin
            model_reset();
        end else begin
            acc  = in_valid && model_ready();
            fire = (mq.size() != 0) && out_ready;
            if (fire) last = mq.pop_front();
            if (acc) mq.push_back(in_data);
        end
    endtask

    // Drives inputs just after an edge, then waits to the falling edge.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                        input logic ordy, input logic fl);
        drive(v, d, ordy, fl);
        check_model(tag);
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();

        // Streaming, accept+fire in ONE, flush with one entry held.
        tbl[0]  = '{"s11",   1, 8'h11, 1, 0, 0, RVAL,  1, 0};
        tbl[1]  = '{"s22",   1, 8'h22, 1, 0, 1, 8'h11, 1, 1};
        tbl[2]  = '{"s33",   1, 8'h33, 1, 0, 1, 8'h22, 1, 1};
        tbl[3]  = '{"sdrn",  0, 8'h00, 1, 0, 1, 8'h33, 1, 1};
        tbl[4]  = '{"sidle", 0, 8'h00, 1, 0, 0, 8'h33, 1, 0};
        tbl[5]  = '{"a55",   1, 8'h55, 0, 0, 0, 8'h33, 1, 0};
        tbl[6]  = '{"a66",   1, 8'h66, 1, 0, 1, 8'h55, 1, 1};
        tbl[7]  = '{"o66",   0, 8'h00, 1, 0, 1, 8'h66, 1, 1};
        tbl[8]  = '{"e66",   0, 8'h00, 1, 0, 0, 8'h66, 1, 0};
        tbl[9]  = '{"f44",   1, 8'h44, 0, 0, 0, 8'h66, 1, 0};
        tbl[10] = '{"fl",    1, 8'h99, 1, 1, 1, 8'h44, 1, 1};
        tbl[11] = '{"pfl",   0, 8'h00, 1, 0, 0, RVAL,  1, 0};

        // Reset held with random inputs: outputs must sit at reset values.
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            chk("rst.valid", {7'd0, out_valid}, 8'd0);
            chk("rst.data", out_data, RVAL);
            chk("rst.ready", {7'd0, in_ready}, 8'd1);
            chk("rst.count", {6'd0, count}, 8'd0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            chk({tbl[i].name, ".valid"}, {7'd0, out_valid}, {7'd0, tbl[i].e_valid});
            chk({tbl[i].name, ".data"}, out_data, tbl[i].e_data);
            chk({tbl[i].name, ".ready"}, {7'd0, in_ready}, {7'd0, tbl[i].e_ready});
            chk({tbl[i].name, ".count"}, {6'd0, count}, {6'd0, tbl[i].e_count});
            check_model(tbl[i].name);
            tick();
        end

`ifdef PIPE_STAGE_SKID_EN
        // Backpressure: two words pile up, head stays stable, then drain in order.
        step("bpA1", 1, 8'hA1, 0, 0);
        step("bpA2", 1, 8'hA2, 0, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bp.count2", {6'd0, count}, 8'd2);
        chk("bp.ready0", {7'd0, in_ready}, 8'd0);
        chk("bp.headA1", out_data, 8'hA1);
        tick();
        drive(1'b1, 8'hEE, 1'b0, 1'b0);  // refused: not ready
        chk("bp.stable", out_data, 8'hA1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp.fire1", out_data, 8'hA1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp.fire2", out_data, 8'hA2);
        chk("bp.ready1", {7'd0, in_ready}, 8'd1);
        chk("bp.count1", {6'd0, count}, 8'd1);
        tick();
        step("bp.empty", 0, 8'h00, 1, 0);

        // Flush while full, with a concurrent accept offer and fire.
        step("ffB1", 1, 8'hB1, 0, 0);
        step("ffB2", 1, 8'hB2, 0, 0);
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        chk("ff.two", {6'd0, count}, 8'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("ff.valid", {7'd0, out_valid}, 8'd0);
            chk("ff.data", out_data, RVAL);
            chk("ff.count", {6'd0, count}, 8'd0);
            tick();
        end
`else
        // Non-skid: ready follows out_ready combinationally while M is full.
        step("nsk71", 1, 8'h71, 0, 0);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        chk("nsk.ready0", {7'd0, in_ready}, 8'd0);
        out_ready = 1'b1;
        #1;
        chk("nsk.ready1", {7'd0, in_ready}, 8'd1);
        chk("nsk.head", out_data, 8'h71);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("nsk.data77", out_data, 8'h77);
        chk("nsk.count", {6'd0, count}, 8'd1);
        tick();
        step("nsk.drain", 0, 8'h00, 1, 0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-transfer, away from any clock edge.
        step("ar1", 1, 8'hD1, 0, 0);
        step("ar2", 1, 8'hD2, 0, 0);
        drive(1'b1, 8'hD3, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.valid", {7'd0, out_valid}, 8'd0);
        chk("arst.data", out_data, RVAL);
        chk("arst.ready", {7'd0, in_ready}, 8'd1);
        chk("arst.count", {6'd0, count}, 8'd0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        step("post", 1, 8'h3C, 1, 0);
        step("post2", 0, 8'h00, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
